vpu_lane_rob: RTL and testbench

- Parametrised successor of the single VPU lane: one lane with an internal 1-cycle ALU path and a MUL_LAT-cycle multiply path.
- Adds a valid/ready issue handshake, output backpressure and an in-order completion buffer, so results always leave in issue order even when an ALU op overtakes an earlier MUL op.
- Sits between the VPU issue stage and the lane writeback arbiter. One instance per lane.

---
 rtl/vpu_lane_rob.sv | 186 ++++++++++++++++++
 tb/tb_vpu_lane_rob.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vpu_lane_rob.sv
// One VPU lane: 1-cycle ALU, MUL_LAT-cycle multiplier and an in-order completion buffer,
// so results retire in issue order under writeback backpressure.
module vpu_lane_rob #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              fu_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] operand1_i,
    input  logic [DATA_W-1:0] operand2_i,
    input  logic [DATA_W-1:0] operand3_i,
    input  logic              mask_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              result_en_o,
    output logic [DATA_W-1:0] result_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    function automatic logic [DATA_W-1:0] alu_calc(input logic [1:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mul_calc(input logic [1:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c);
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   r;
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (op)
            2'b00:   r = prod[DATA_W-1:0];
            2'b01:   r = prod[2*DATA_W-1:DATA_W];
            2'b10:   r = c + prod[DATA_W-1:0];
            default: r = c - prod[DATA_W-1:0];
        endcase
        return r;
    endfunction

    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q  [DEPTH];
    logic              alloc_q [DEPTH];
    logic              en_q    [DEPTH];
    logic [DATA_W-1:0] res_q   [DEPTH];

    logic              issue, pop, head_done;
    logic [DATA_W-1:0] alu_res;

    // MUL completion write port, one per cycle, never aliasing the ALU write (different tags).
    logic              cmp_v;
    logic [PTR_W-1:0]  cmp_tag;
    logic              cmp_en;
    logic [DATA_W-1:0] cmp_res;

    // Registered-only so writeback never sees a combinational loop through result_ready_i.
    assign ready_o = (count_q != FULL);
    assign issue   = valid_i && ready_o;
    assign pop     = result_valid_o && result_ready_i;
    assign alu_res = mask_i ? alu_calc(op_i, operand1_i, operand2_i) : operand3_i;

    if (MUL_LAT == 1) begin : g_mul_comb
        assign cmp_v   = issue && fu_i;
        assign cmp_tag = tail_q;
        assign cmp_en  = mask_i;
        assign cmp_res = mask_i ? mul_calc(op_i, operand1_i, operand2_i, operand3_i)
                                : operand3_i;
    end else begin : g_mul_pipe
        localparam int unsigned STAGES = MUL_LAT - 1;

        logic [STAGES-1:0] v_q;
        logic [STAGES-1:0] mask_q;
        logic [PTR_W-1:0]  tag_q [STAGES];
        logic [1:0]        op_q  [STAGES];
        logic [DATA_W-1:0] a_q   [STAGES];
        logic [DATA_W-1:0] b_q   [STAGES];
        logic [DATA_W-1:0] c_q   [STAGES];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q    <= '0;
                mask_q <= '0;
                for (int i = 0; i < int'(STAGES); i++) begin
                    tag_q[i] <= '0;
                    op_q[i]  <= '0;
                    a_q[i]   <= '0;
                    b_q[i]   <= '0;
                    c_q[i]   <= '0;
                end
            end else begin
                v_q[0] <= issue && fu_i;
                if (issue && fu_i) begin
                    mask_q[0] <= mask_i;
                    tag_q[0]  <= tail_q;
                    op_q[0]   <= op_i;
                    a_q[0]    <= operand1_i;
                    b_q[0]    <= operand2_i;
                    c_q[0]    <= operand3_i;
                end
                for (int i = 1; i < int'(STAGES); i++) begin
                    v_q[i]    <= v_q[i-1];
                    mask_q[i] <= mask_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                    op_q[i]   <= op_q[i-1];
                    a_q[i]    <= a_q[i-1];
                    b_q[i]    <= b_q[i-1];
                    c_q[i]    <= c_q[i-1];
                end
            end
        end

        // Product is formed in the last cycle so the done bit lands at issue + MUL_LAT.
        assign cmp_v   = v_q[STAGES-1];
        assign cmp_tag = tag_q[STAGES-1];
        assign cmp_en  = mask_q[STAGES-1];
        assign cmp_res = mask_q[STAGES-1]
                       ? mul_calc(op_q[STAGES-1], a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1])
                       : c_q[STAGES-1];
    end

    always_comb begin
        count_d = count_q;
        if (issue && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !issue) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                done_q[i]  <= 1'b0;
                alloc_q[i] <= 1'b0;
                en_q[i]    <= 1'b0;
                res_q[i]   <= '0;
            end
        end else begin
            count_q <= count_d;
            if (pop) begin
                done_q[head_q]  <= 1'b0;
                alloc_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (issue) begin
                alloc_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
                if (!fu_i) begin
                    done_q[tail_q] <= 1'b1;
                    res_q[tail_q]  <= alu_res;
                    en_q[tail_q]   <= mask_i;
                end
            end
            if (cmp_v) begin
                done_q[cmp_tag] <= 1'b1;
                res_q[cmp_tag]  <= cmp_res;
                en_q[cmp_tag]   <= cmp_en;
            end
        end
    end

    assign head_done      = done_q[head_q] && alloc_q[head_q];
    assign result_valid_o = head_done;
    assign result_en_o    = head_done && en_q[head_q];
    assign result_o       = head_done ? res_q[head_q] : '0;

endmodule

// File: tb/tb_vpu_lane_rob.sv
// Directed bench for vpu_lane_rob at DATA_W=8, MUL_LAT=2, DEPTH=4.
module tb_vpu_lane_rob;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid, ready, fu, mask;
    logic [1:0] op;
    logic [7:0] op1, op2, op3;
    logic       result_valid, result_ready, result_en;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vpu_lane_rob #(
        .DATA_W (8),
        .MUL_LAT(2),
        .DEPTH  (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (valid),
        .ready_o       (ready),
        .fu_i          (fu),
        .op_i          (op),
        .operand1_i    (op1),
        .operand2_i    (op2),
        .operand3_i    (op3),
        .mask_i        (mask),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .result_en_o   (result_en),
        .result_o      (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c, input logic m);
        valid = 1'b1; fu = f; op = o; op1 = a; op2 = b; op3 = c; mask = m;
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; fu = 1'b0; op = 2'b00; op1 = '0; op2 = '0; op3 = '0; mask = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; result_ready = 1'b0;
        idle();
        #2;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", ready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", result_valid); end
        checks++; if (result_en !== 1'b0) begin errors++; $display("FAIL reset en: got %b want 0", result_en); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset result: got %h want 00", result); end
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu_add();
        result_ready = 1'b1;
        drive(1'b0, 2'b00, 8'd5, 8'd7, 8'd0, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add early valid: got %b want 0", result_valid); end
        step(); idle();
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL add valid: got %b want 1", result_valid); end
        checks++; if (result !== 8'd12) begin errors++; $display("FAIL add result: got %0d want 12", result); end
        checks++; if (result_en !== 1'b1) begin errors++; $display("FAIL add en: got %b want 1", result_en); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL add ready: got %b want 1", ready); end
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add drained: got %b want 0", result_valid); end
    endtask

    task automatic test_mul_then_alu();
        result_ready = 1'b1;
        drive(1'b1, 2'b00, 8'd3, 8'd4, 8'd0, 1'b1);
        step();
        drive(1'b0, 2'b01, 8'd10, 8'd3, 8'd0, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL order c1 valid: got %b want 0", result_valid); end
        step(); idle();
        checks++; if (result_valid !== 1'b1 || result !== 8'd12) begin
            errors++; $display("FAIL order first: got v=%b %0d want v=1 12", result_valid, result); end
        step();
        checks++; if (result_valid !== 1'b1 || result !== 8'd7) begin
            errors++; $display("FAIL order second: got v=%b %0d want v=1 7", result_valid, result); end
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL order drained: got %b want 0", result_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] a_tab [5] = '{8'h0F, 8'h12, 8'hAA, 8'h81, 8'h11};
        logic [7:0] b_tab [5] = '{8'hF0, 8'h34, 8'h0F, 8'h01, 8'h11};
        result_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'b11, a_tab[k], b_tab[k], 8'h00, 1'b1);
            checks++; if (ready !== (k < 4)) begin
                errors++; $display("FAIL full ready[%0d]: got %b want %b", k, ready, (k < 4)); end
            step();
        end
        idle();
        checks++; if (ready !== 1'b0 || result !== 8'hFF) begin
            errors++; $display("FAIL full hold: got ready=%b %h want ready=0 ff", ready, result); end
        step();
        checks++; if (result !== 8'hFF || result_en !== 1'b1) begin
            errors++; $display("FAIL full stable: got %h en=%b want ff en=1", result, result_en); end
        result_ready = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full pop ready same cycle: got %b want 0", ready); end
        step();
        checks++; if (ready !== 1'b1 || result !== 8'h26) begin
            errors++; $display("FAIL full after pop: got ready=%b %h want ready=1 26", ready, result); end
        step();
        checks++; if (result !== 8'hA5) begin errors++; $display("FAIL full third: got %h want a5", result); end
        step();
        checks++; if (result !== 8'h80) begin errors++; $display("FAIL full fourth: got %h want 80", result); end
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL full fifth ignored: got %b want 0", result_valid); end
    endtask

    task automatic test_masked_mac();
        result_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            drive(1'b1, 2'b10, 8'd2, 8'd3, 8'd100, m[0]);
            step(); idle();
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mac[%0d] early: got %b want 0", m, result_valid); end
            step();
            checks++; if (result !== (m == 1 ? 8'd106 : 8'd100) || result_en !== m[0]) begin
                errors++; $display("FAIL mac[%0d]: got %0d en=%b want %0d en=%b", m, result, result_en,
                                   (m == 1 ? 106 : 100), m[0]); end
            step();
        end
    endtask

    task automatic test_width();
        result_ready = 1'b1;
        drive(1'b0, 2'b00, 8'hFF, 8'h02, 8'h00, 1'b1);
        step();
        checks++; if (result_valid !== 1'b1 || result !== 8'h01) begin
            errors++; $display("FAIL wrap add: got v=%b %h want v=1 01", result_valid, result); end
        drive(1'b1, 2'b01, 8'hFF, 8'hFF, 8'h00, 1'b1);
        step(); idle();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mulh early: got %b want 0", result_valid); end
        step();
        checks++; if (result !== 8'hFE) begin errors++; $display("FAIL mulh: got %h want fe", result); end
        drive(1'b1, 2'b11, 8'd3, 8'd4, 8'd5, 1'b1);
        step();
        drive(1'b0, 2'b10, 8'hF0, 8'h3C, 8'h00, 1'b1);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL msub wait: got %b want 0", result_valid); end
        step(); idle();
        checks++; if (result !== 8'hF9) begin errors++; $display("FAIL msub: got %h want f9", result); end
        step();
        checks++; if (result !== 8'h30) begin errors++; $display("FAIL and behind mul: got %h want 30", result); end
        step();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL width drained: got %b want 0", result_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        result_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) drive(1'b0, 2'b00, 8'(k), 8'h20, 8'h00, 1'b1);
            else idle();
            if (k >= 1) begin
                want = 8'h20 + 8'(k - 1);
                checks++; if (result_valid !== 1'b1 || result !== want || ready !== 1'b1) begin
                    errors++; $display("FAIL stream[%0d]: got v=%b %h rdy=%b want v=1 %h rdy=1",
                                       k, result_valid, result, ready, want); end
            end
            step();
        end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL stream drained: got %b want 0", result_valid); end
    endtask

    task automatic test_async_reset();
        result_ready = 1'b0;
        drive(1'b0, 2'b00, 8'd1, 8'd1, 8'd0, 1'b1);
        step();
        drive(1'b0, 2'b00, 8'd2, 8'd2, 8'd0, 1'b1);
        step();
        drive(1'b1, 2'b00, 8'd3, 8'd3, 8'd0, 1'b1);
        step(); idle();
        checks++; if (result_valid !== 1'b1 || result !== 8'd2) begin
            errors++; $display("FAIL pre-reset head: got v=%b %0d want v=1 2", result_valid, result); end
        #2 rst = 1'b1;
        #1;
        checks++; if (result_valid !== 1'b0 || ready !== 1'b1 || result !== 8'h00) begin
            errors++; $display("FAIL async reset: got v=%b rdy=%b %h want v=0 rdy=1 00",
                               result_valid, ready, result); end
        step();
        rst = 1'b0; result_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (result_valid !== 1'b0 || ready !== 1'b1) begin
                errors++; $display("FAIL stale after reset[%0d]: got v=%b rdy=%b want v=0 rdy=1",
                                   k, result_valid, ready); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_add();
        test_mul_then_alu();
        test_backpressure();
        test_masked_mac();
        test_width();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
